// File: rtl/uart_mmio_ctrl.sv
// MMIO front end for the shared UART: TX/RX FIFOs, TX sequencer, status/irq.
// Ports: CPU bus (addr/wdata/we/re/rdata), TX valid/ready, RX strobe, irq.
module uart_mmio_ctrl #(
  parameter int unsigned          BIT_WIDTH  = 32,
  parameter int unsigned          DATA_WIDTH = 8,
  parameter int unsigned          FIFO_DEPTH = 4,
  parameter logic [BIT_WIDTH-1:0] BASE_ADDR  = 32'h1001_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BIT_WIDTH-1:0]  addr,
  input  logic [BIT_WIDTH-1:0]  wdata,
  input  logic                  we,
  input  logic                  re,
  output logic [BIT_WIDTH-1:0]  rdata,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_ready,
  input  logic                  rx_strobe,
  input  logic [DATA_WIDTH-1:0] rx_byte,
  output logic                  irq
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } tx_state_t;

  tx_state_t state, state_nx;

  logic [BIT_WIDTH-1:0] off;
  logic in_win;
  logic sel_tx, sel_rx, sel_st, sel_ctrl;

  logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [CW-1:0] tx_cnt;
  logic tx_full, tx_empty, tx_wr, tx_push, tx_pop;

  logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [CW-1:0] rx_cnt;
  logic rx_full, rx_empty, rx_wr, rx_push, rx_pop;

  logic [2:0] ctrl;
  logic tx_en, rx_en, rx_ie;
  logic rx_ovr, tx_ovf;
  logic ovr_set, ovf_set, w1c_ovr, w1c_ovf;
  logic [DATA_WIDTH-1:0] tx_data_q;
  logic [BIT_WIDTH-1:0] status;

  wire unused_ok = ^wdata[BIT_WIDTH-1:DATA_WIDTH];

  assign off      = addr - BASE_ADDR;
  assign in_win   = (off[BIT_WIDTH-1:4] == '0) && (off[1:0] == 2'b00);
  assign sel_tx   = in_win && (off[3:2] == 2'd0);
  assign sel_rx   = in_win && (off[3:2] == 2'd1);
  assign sel_st   = in_win && (off[3:2] == 2'd2);
  assign sel_ctrl = in_win && (off[3:2] == 2'd3);

  assign tx_en = ctrl[0];
  assign rx_en = ctrl[1];
  assign rx_ie = ctrl[2];

  assign tx_full  = (tx_cnt == CW'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt == '0);

  // A full FIFO still accepts a push when the same edge frees a slot.
  assign tx_pop  = (state == IDLE) && tx_en && !tx_empty;
  assign tx_wr   = we && sel_tx;
  assign tx_push = tx_wr && (!tx_full || tx_pop);
  assign ovf_set = tx_wr && tx_full && !tx_pop;

  assign rx_pop  = re && sel_rx && !rx_empty;
  assign rx_wr   = rx_strobe && rx_en;
  assign rx_push = rx_wr && (!rx_full || rx_pop);
  assign ovr_set = rx_wr && rx_full && !rx_pop;

  assign w1c_ovr = we && sel_st && wdata[4];
  assign w1c_ovf = we && sel_st && wdata[5];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= wdata[DATA_WIDTH-1:0];
    if (rx_push) rx_mem[rx_wp] <= rx_byte;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // Sticky flags: a same-cycle set beats the write-1-clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl   <= 3'b011;
      rx_ovr <= 1'b0;
      tx_ovf <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (we && sel_ctrl) ctrl <= wdata[2:0];
      rx_ovr <= ovr_set | (rx_ovr & ~w1c_ovr);
      tx_ovf <= ovf_set | (tx_ovf & ~w1c_ovf);
      irq    <= rx_ie && (!rx_empty || rx_ovr);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tx_data_q <= '0;
    end else begin
      state <= state_nx;
      if (tx_pop) tx_data_q <= tx_mem[tx_rp];
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (tx_pop) state_nx = SEND;
      SEND:    if (tx_ready) state_nx = GAP;
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign tx_valid = (state == SEND);
  assign tx_data  = tx_data_q;

  always_comb begin
    status = '0;
    status[0] = tx_full;
    status[1] = tx_empty;
    status[2] = !rx_empty;
    status[3] = rx_full;
    status[4] = rx_ovr;
    status[5] = tx_ovf;
    status[6] = (state != IDLE);
    status[8 +: CW]  = tx_cnt;
    status[12 +: CW] = rx_cnt;
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_rx:   if (!rx_empty) rdata = BIT_WIDTH'(rx_mem[rx_rp]);
      sel_st:   rdata = status;
      sel_ctrl: rdata = BIT_WIDTH'(ctrl);
      default:  rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed bench for uart_mmio_ctrl with TX/RX scoreboards.
// Drives the CPU bus after each rising edge and checks mid-cycle.
module tb_uart_mmio_ctrl;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic        we, re;
  logic        tx_valid, tx_ready;
  logic [7:0]  tx_data;
  logic        rx_strobe;
  logic [7:0]  rx_byte;
  logic        irq;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [31:0] tx_q [$];
  logic [31:0] rx_q [$];
  int hs_cyc [$];

  uart_mmio_ctrl dut (
    .clk(clk), .rst(rst),
    .addr(addr), .wdata(wdata), .we(we), .re(re), .rdata(rdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_strobe(rx_strobe), .rx_byte(rx_byte), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // TX scoreboard: compare every accepted character with the queue head.
  always @(negedge clk) begin
    if (rst && tx_valid && tx_ready) begin
      hs_cyc.push_back(cyc);
      if (tx_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $error("FAIL tx_unexp: observed %h expected none", tx_data);
      end else begin
        chk("tx_data", {24'h0, tx_data}, tx_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    addr = BASE + off;
    wdata = d;
    we = 1'b1;
    if (off == 32'h0) tx_q.push_back({24'h0, d[7:0]});
    step();
    we = 1'b0;
  endtask

  task automatic wr_drop(input logic [7:0] d);
    addr = BASE;
    wdata = {24'h0, d};
    we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic peek(input logic [31:0] a, input logic [31:0] exp,
                      input string tag);
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic rd_rx(input string tag);
    logic [31:0] exp;
    exp = (rx_q.size() != 0) ? rx_q.pop_front() : 32'h0;
    addr = BASE + 32'h4;
    re = 1'b1;
    #1;
    chk(tag, rdata, exp);
    step();
    re = 1'b0;
  endtask

  task automatic drain_tx(input string tag);
    for (int i = 0; i < 60 && tx_q.size() != 0; i++) step();
    chk(tag, tx_q.size(), 0);
  endtask

  initial begin
    rst = 1'b0;
    addr = BASE + 32'h8;
    wdata = '0;
    we = 1'b0;
    re = 1'b0;
    tx_ready = 1'b0;
    rx_strobe = 1'b0;
    rx_byte = '0;
    #12;
    chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    peek(BASE + 32'h8, 32'h2, "rst_status");
    @(negedge clk);
    rst = 1'b1;
    step();

    peek(BASE + 32'h8, 32'h2, "status_reset");
    peek(BASE + 32'hC, 32'h3, "ctrl_reset");
    peek(BASE + 32'h0, 32'h0, "txdata_read");
    step();
    peek(BASE + 32'h10, 32'h0, "out_of_window");
    peek(BASE + 32'h4, 32'h0, "rx_empty_read");

    // Two characters back to back with the serializer always ready.
    tx_ready = 1'b1;
    hs_cyc.delete();
    wr(32'h0, 32'h41);
    wr(32'h0, 32'h42);
    drain_tx("tx_ab_drain");
    step();
    step();
    chk("tx_ab_count", hs_cyc.size(), 2);
    if (hs_cyc.size() == 2)
      chk("tx_char_period", hs_cyc[1] - hs_cyc[0], 3);
    peek(BASE + 32'h8, 32'h2, "status_after_ab");

    // Serializer stalled: one character in SEND, four held, sixth dropped.
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) wr(32'h0, 32'h10 + i);
    chk("tx_valid_stall", {31'h0, tx_valid}, 32'h1);
    chk("tx_data_stall", {24'h0, tx_data}, 32'h10);
    peek(BASE + 32'h8, 32'h441, "status_tx_full");
    wr_drop(8'h15);
    peek(BASE + 32'h8, 32'h461, "status_tx_ovf");
    wr(32'h8, 32'h20);
    peek(BASE + 32'h8, 32'h441, "status_ovf_clr");
    tx_ready = 1'b1;
    drain_tx("tx_stall_drain");
    step();
    step();
    chk("tx_valid_idle", {31'h0, tx_valid}, 32'h0);
    chk("tx_data_hold", {24'h0, tx_data}, 32'h14);
    peek(BASE + 32'h8, 32'h2, "status_tx_done");

    // Single received byte with the interrupt enabled.
    wr(32'hC, 32'h7);
    rx_strobe = 1'b1;
    rx_byte = 8'h55;
    rx_q.push_back(32'h55);
    step();
    rx_strobe = 1'b0;
    chk("irq_lag", {31'h0, irq}, 32'h0);
    step();
    chk("irq_set", {31'h0, irq}, 32'h1);
    rd_rx("rx_55");
    chk("irq_after_pop", {31'h0, irq}, 32'h1);
    step();
    chk("irq_clear", {31'h0, irq}, 32'h0);
    peek(BASE + 32'h8, 32'h2, "status_rx_empty");

    // Overrun: five bytes into a four-entry FIFO.
    for (int i = 0; i < 5; i++) begin
      rx_strobe = 1'b1;
      rx_byte = 8'hA0 + 8'(i);
      if (rx_q.size() < 4) rx_q.push_back({24'h0, rx_byte});
      step();
    end
    rx_strobe = 1'b0;
    peek(BASE + 32'h8, 32'h401E, "status_rx_ovr");
    step();
    chk("irq_ovr", {31'h0, irq}, 32'h1);
    for (int i = 0; i < 5; i++) rd_rx("rx_ovr_read");
    peek(BASE + 32'h8, 32'h12, "status_ovr_sticky");
    step();
    chk("irq_ovr_only", {31'h0, irq}, 32'h1);
    wr(32'h8, 32'h10);
    peek(BASE + 32'h8, 32'h2, "status_ovr_clr");
    step();
    chk("irq_after_clr", {31'h0, irq}, 32'h0);

    // Full FIFO: push and pop on the same edge.
    for (int i = 0; i < 4; i++) begin
      rx_strobe = 1'b1;
      rx_byte = 8'hB0 + 8'(i);
      rx_q.push_back({24'h0, rx_byte});
      step();
    end
    rx_byte = 8'hB4;
    rx_q.push_back(32'hB4);
    rd_rx("rx_full_pop");
    rx_strobe = 1'b0;
    peek(BASE + 32'h8, 32'h400E, "status_full_pushpop");

    // Overrun set and write-1-clear on the same edge: set wins.
    rx_strobe = 1'b1;
    rx_byte = 8'hB5;
    wr(32'h8, 32'h10);
    rx_strobe = 1'b0;
    peek(BASE + 32'h8, 32'h401E, "status_set_wins");
    for (int i = 0; i < 4; i++) rd_rx("rx_wrap_read");
    wr(32'h8, 32'h10);

    // rx_en low: strobes are ignored.
    wr(32'hC, 32'h5);
    rx_strobe = 1'b1;
    rx_byte = 8'hCC;
    step();
    rx_strobe = 1'b0;
    peek(BASE + 32'h8, 32'h2, "status_rx_dis");
    peek(BASE + 32'hC, 32'h5, "ctrl_readback");

    // Reset while a character sits in SEND.
    tx_ready = 1'b0;
    wr(32'h0, 32'h77);
    step();
    chk("send_before_rst", {31'h0, tx_valid}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_valid", {31'h0, tx_valid}, 32'h0);
    tx_q.delete();
    peek(BASE + 32'h8, 32'h2, "status_mid_rst");
    peek(BASE + 32'hC, 32'h3, "ctrl_mid_rst");
    @(negedge clk);
    rst = 1'b1;
    step();
    step();
    chk("valid_post_rst", {31'h0, tx_valid}, 32'h0);
    peek(BASE + 32'h8, 32'h2, "status_post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
